split_mix_sequencer: RTL
========================

# split_mix_sequencer

Cycle-accurate controller for a parametrised split-mix assay. `NUM_CH` parallel chamber channels fill and dwell concurrently. Finished channels are merged in index order through one shared mixer. The merged result then passes a detect chamber and is presented on a valid/ready handshake. The block sits between the assay host and the valve/heater drivers of a split-mixer netlist, replacing fixed, hand-wired chamber chains with a configurable schedule.

## Interface
- `NUM_CH`, 3: number of parallel chamber channels (2..16)
- `CNT_W`, 16: width of all cycle-count fields
- `FILL_CYC`, 2: cycles each channel inlet valve stays open (≥1)
- `clk` in 1: single clock; all state changes on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: launch request, sampled when idle
- `abort` in 1: synchronous abort, highest priority after reset
- `ch_en` in NUM_CH: channel enable mask, captured at start
- `dwell` in NUM_CH*CNT_W: per-channel dwell cycles, packed with ch0 in the LSBs; captured at start
- `mix_cyc` in CNT_W: mixer-on cycles per merge step; captured at start
- `det_cyc` in CNT_W: detect cycles; captured at start
- `out_ready` in 1: downstream accepts result
- `inlet_valve` out NUM_CH: channel inlet open
- `chamber_busy` out NUM_CH: channel is filling, dwelling, or holding an unmerged sample
- `mixer_on` out 1: shared mixer active
- `mix_sel` out $clog2(NUM_CH): channel currently being merged; 0 when not mixing
- `detect_on` out 1: detect chamber active
- `out_valid` out 1: result available
- `busy` out 1: any operation in progress
- `err` out 1: one-cycle error pulse

## Operation
- Every output is registered. Reset value of all outputs is 0.
- **Per-channel FSM:** C_IDLE → C_FILL (FILL_CYC cycles, `inlet_valve` high) → C_DWELL (dwell cycles) → C_READY. The channel stays in C_READY until the top FSM consumes it, then returns to C_IDLE.
- `chamber_busy` is high in C_FILL, C_DWELL and C_READY.
- A dwell, `mix_cyc` or `det_cyc` value of 0 is treated as 1.
- **Top FSM states:** T_IDLE, T_MERGE, T_MIX, T_DETECT, T_OUT.
- T_IDLE: `start` high and `ch_en` nonzero captures the configuration and launches every enabled channel at once. Next state is T_MERGE with the pointer at the lowest enabled channel. `start` with `ch_en` = 0 does not launch and pulses `err`.
- T_MERGE: waits for the pointed-to channel to reach C_READY.
  - First enabled channel: it becomes the accumulator. It is consumed with no mix.
  - Any later enabled channel: it is consumed and the FSM enters T_MIX, with `mixer_on` high and `mix_sel` equal to that channel for `mix_cyc` cycles.
  - Disabled channels are skipped at zero cost.
- After the highest enabled channel has been handled, the FSM enters T_DETECT. `detect_on` is high for `det_cyc` cycles.
- T_OUT: `out_valid` is high and held until the cycle in which `out_ready` is also high. The FSM then returns to T_IDLE. `out_ready` arriving early has no effect.
- `start` while not in T_IDLE is ignored and pulses `err`.
- `abort` in any state: the next edge forces all FSMs to idle and all counters to 0, and every output drops to 0. If `abort` and `start` are high together, `abort` wins. In T_IDLE, `abort` has no visible effect.
- `rst_n` low mid-operation asynchronously clears all state and outputs. The first `start` is accepted on the first edge after release.
- `busy` is high in every top state except T_IDLE.
- Counters are CNT_W bits and load (value − 1). A dwell of 2^CNT_W − 1 must not wrap.

## Timing
- Cycle numbering: cycle 0 is the edge that samples `start`.
- For channel i with dwell Di:
  - `inlet_valve[i]` is high in cycles 1..F.
  - Dwell occupies cycles F+1..F+Di.
  - C_READY is visible from cycle F+Di+1.
  - F = FILL_CYC.
- Consumption happens in the same cycle READY is seen in T_MERGE. T_MIX or T_DETECT begins on the next cycle.
- Single enabled channel, M = mix_cyc, T = det_cyc:
  - `detect_on` is high in cycles F+D+2..F+D+T+1.
  - `out_valid` is first high in cycle F+D+T+2.
- Merge steps are serial. A channel that finishes dwelling early holds in C_READY with `chamber_busy` high until its turn.

## Test plan
- **Single channel:** ch_en=001, F=2, D0=3, T=2, out_ready=1. Required: `inlet_valve[0]` high in cycles 1–2; `detect_on` high in cycles 7–8; `out_valid` high for exactly cycle 9; `busy` low from cycle 10.
- **Two-channel merge:** ch_en=011, D0=3, D1=5, M=4, T=2. Required: `mixer_on` high in cycles 9–12 with `mix_sel`=1; `detect_on` high in cycles 13–14; `out_valid` high at cycle 15. `chamber_busy[0]` drops after cycle 6; `chamber_busy[1]` drops after cycle 8.
- **Sparse mask:** ch_en=101, D0=D2=1, M=1, T=1. Required: channel 1 never opens; `mix_sel`=2 in the single mix cycle.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid` rises. Required: `out_valid` stays high; a `start` issued during that time pulses `err` and is ignored; the first high `out_ready` returns the block to idle on the next cycle.
- **Abort and reset:**
  - Assert `abort` during T_MIX. Required: all outputs are 0 on the next cycle; a new `start` is accepted immediately after.
  - Drop `rst_n` during dwell. Required: outputs clear without waiting for a clock edge.
- **Errors and limits:**
  - `start` with ch_en=000 → one-cycle `err` pulse and `busy` stays 0.
  - dwell=0 → behaves as 1.
  - dwell=0xFFFF → 65535 cycles of dwell with no wrap.

Source files
------------

// File: rtl/split_mix_sequencer.sv
// Split-mix assay sequencer: parallel fill/dwell channels merged
// in index order through one shared mixer, then detect and hand-off.
module split_mix_sequencer #(
  parameter int NUM_CH   = 3,
  parameter int CNT_W    = 16,
  parameter int FILL_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*CNT_W-1:0] dwell,
  input  logic [CNT_W-1:0]        mix_cyc,
  input  logic [CNT_W-1:0]        det_cyc,
  input  logic                    out_ready,
  output logic [NUM_CH-1:0]       inlet_valve,
  output logic [NUM_CH-1:0]       chamber_busy,
  output logic                    mixer_on,
  output logic [$clog2(NUM_CH)-1:0] mix_sel,
  output logic                    detect_on,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    err
);

  localparam int SW = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] FILL_LD = CNT_W'(FILL_CYC - 1);

  typedef enum logic [1:0] {
    C_IDLE,
    C_FILL,
    C_DWELL,
    C_READY
  } cst_t;

  typedef enum logic [2:0] {
    T_IDLE,
    T_MERGE,
    T_MIX,
    T_DETECT,
    T_OUT
  } tst_t;

  function automatic logic [CNT_W-1:0] ld(
    input logic [CNT_W-1:0] v
  );
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  tst_t             tst;
  logic [CNT_W-1:0] tcnt;
  logic [SW-1:0]    ptr;
  logic             first;
  logic             launch;
  logic [NUM_CH-1:0] en_q;
  logic [CNT_W-1:0] mix_ld;
  logic [CNT_W-1:0] det_ld;
  logic [CNT_W-1:0] dw_ld [NUM_CH];

  logic [NUM_CH-1:0] rdy;
  logic [NUM_CH-1:0] consume;
  logic              ptr_rdy;
  logic [SW-1:0]     first_idx;
  logic [SW-1:0]     nxt;
  logic              has_nxt;

  always_comb begin
    first_idx = '0;
    nxt       = '0;
    has_nxt   = 1'b0;
    ptr_rdy   = 1'b0;
    consume   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_en[i]) first_idx = SW'(i);
      if (en_q[i] && i > int'(ptr)) begin
        nxt     = SW'(i);
        has_nxt = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(ptr) == i && rdy[i]) ptr_rdy = 1'b1;
      consume[i] = (tst == T_MERGE) && !abort &&
                   (int'(ptr) == i) && rdy[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tst       <= T_IDLE;
      tcnt      <= '0;
      ptr       <= '0;
      first     <= 1'b0;
      launch    <= 1'b0;
      en_q      <= '0;
      mix_ld    <= '0;
      det_ld    <= '0;
      for (int i = 0; i < NUM_CH; i++) dw_ld[i] <= '0;
      mixer_on  <= 1'b0;
      mix_sel   <= '0;
      detect_on <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err    <= 1'b0;
      launch <= 1'b0;
      if (abort) begin
        tst       <= T_IDLE;
        tcnt      <= '0;
        ptr       <= '0;
        first     <= 1'b0;
        mixer_on  <= 1'b0;
        mix_sel   <= '0;
        detect_on <= 1'b0;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        if (start && tst != T_IDLE) err <= 1'b1;
        unique case (tst)
          T_IDLE: begin
            if (start) begin
              if (|ch_en) begin
                en_q   <= ch_en;
                mix_ld <= ld(mix_cyc);
                det_ld <= ld(det_cyc);
                for (int i = 0; i < NUM_CH; i++)
                  dw_ld[i] <= ld(dwell[i*CNT_W +: CNT_W]);
                launch <= 1'b1;
                ptr    <= first_idx;
                first  <= 1'b1;
                busy   <= 1'b1;
                tst    <= T_MERGE;
              end else begin
                err <= 1'b1;
              end
            end
          end
          T_MERGE: begin
            if (ptr_rdy) begin
              first <= 1'b0;
              // The first channel seeds the accumulator; no mix step.
              if (!first) begin
                tst      <= T_MIX;
                mixer_on <= 1'b1;
                mix_sel  <= ptr;
                tcnt     <= mix_ld;
              end else if (has_nxt) begin
                ptr <= nxt;
              end else begin
                tst       <= T_DETECT;
                detect_on <= 1'b1;
                tcnt      <= det_ld;
              end
            end
          end
          T_MIX: begin
            if (tcnt == '0) begin
              mixer_on <= 1'b0;
              mix_sel  <= '0;
              if (has_nxt) begin
                ptr <= nxt;
                tst <= T_MERGE;
              end else begin
                tst       <= T_DETECT;
                detect_on <= 1'b1;
                tcnt      <= det_ld;
              end
            end else begin
              tcnt <= tcnt - 1'b1;
            end
          end
          T_DETECT: begin
            if (tcnt == '0) begin
              detect_on <= 1'b0;
              out_valid <= 1'b1;
              tst       <= T_OUT;
            end else begin
              tcnt <= tcnt - 1'b1;
            end
          end
          T_OUT: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              ptr       <= '0;
              tst       <= T_IDLE;
            end
          end
          default: tst <= T_IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cst_t             st;
    logic [CNT_W-1:0] cnt;
    logic             iv;
    logic             cb;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st  <= C_IDLE;
        cnt <= '0;
        iv  <= 1'b0;
        cb  <= 1'b0;
      end else if (abort) begin
        st  <= C_IDLE;
        cnt <= '0;
        iv  <= 1'b0;
        cb  <= 1'b0;
      end else begin
        unique case (st)
          C_IDLE: begin
            if (launch && en_q[g]) begin
              st  <= C_FILL;
              cnt <= FILL_LD;
              iv  <= 1'b1;
              cb  <= 1'b1;
            end
          end
          C_FILL: begin
            if (cnt == '0) begin
              st  <= C_DWELL;
              cnt <= dw_ld[g];
              iv  <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          C_DWELL: begin
            if (cnt == '0) st <= C_READY;
            else cnt <= cnt - 1'b1;
          end
          C_READY: begin
            if (consume[g]) begin
              st <= C_IDLE;
              cb <= 1'b0;
            end
          end
          default: st <= C_IDLE;
        endcase
      end
    end

    assign rdy[g]          = (st == C_READY);
    assign inlet_valve[g]  = iv;
    assign chamber_busy[g] = cb;
  end

endmodule
